// File: rtl/datapath_pkg.sv
// Shared definitions for the multicycle datapath: ISA field constants,
// FSM state encoding and the ALU operation encoding.
package datapath_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_e;

  function automatic logic funct_valid(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

  function automatic logic instr_valid(input logic [5:0] opcode, input logic [5:0] funct);
    return ((opcode == OP_RTYPE) && funct_valid(funct)) || (opcode == OP_ADDI) ||
           (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_BEQ);
  endfunction

  function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// Shared combinational ALU: add, sub, and, or, signed set-less-than.
module datapath_alu
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y[0] = $signed(a) < $signed(b);
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset core: FSM-sequenced datapath with one shared ALU,
// private instruction memory (MR), data memory (mem) and register file.
module multicycle_datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REGS       = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pru,
  output logic             instr_done,
  output logic             busy,
  output logic             halted
);

  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);
  localparam int RW = $clog2(REGS);
  localparam logic [WIDTH-1:0] PC_MASK = WIDTH'(IMEM_DEPTH * 4 - 1);

  logic [31:0]      MR  [IMEM_DEPTH];
  logic [WIDTH-1:0] mem [DMEM_DEPTH];
  logic [WIDTH-1:0] rf  [REGS];

  state_e           state, next_state;
  logic [31:0]      ir;
  logic [WIDTH-1:0] a_reg, b_reg, alu_out, mdr;

  logic [5:0]       opcode, funct;
  logic [RW-1:0]    rs, rt, rd, wb_dst;
  logic [WIDTH-1:0] imm, wb_val;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  alu_op_e          alu_op;
  logic             alu_zero;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];
  assign rs     = ir[21 +: RW];
  assign rt     = ir[16 +: RW];
  assign rd     = ir[11 +: RW];
  assign imm    = {{(WIDTH-16){ir[15]}}, ir[15:0]};
  assign wb_dst = (opcode == OP_RTYPE) ? rd : rt;
  assign wb_val = (opcode == OP_LW) ? mdr : alu_out;

  // One ALU serves pc+4 in FETCH, the branch target in DECODE, and the instruction in EXEC.
  always_comb begin
    alu_a  = a_reg;
    alu_b  = b_reg;
    alu_op = ALU_ADD;
    case (state)
      ST_FETCH: begin
        alu_a = pc;
        alu_b = WIDTH'(4);
      end
      ST_DECODE: begin
        alu_a = pc;
        alu_b = imm << 2;
      end
      ST_EXEC: begin
        if (opcode == OP_RTYPE) alu_op = funct_to_alu(funct);
        else if (opcode == OP_BEQ) alu_op = ALU_SUB;
        else alu_b = imm;
      end
      default: ;
    endcase
  end

  datapath_alu #(.WIDTH(WIDTH)) u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .op   (alu_op),
    .y    (alu_y),
    .zero (alu_zero)
  );

  always_comb begin
    next_state = state;
    instr_done = 1'b0;
    case (state)
      ST_IDLE:   if (run) next_state = ST_FETCH;
      ST_FETCH:  next_state = ST_DECODE;
      ST_DECODE: next_state = instr_valid(opcode, funct) ? ST_EXEC : ST_HALT;
      ST_EXEC: begin
        if (opcode == OP_BEQ) begin
          instr_done = 1'b1;
          next_state = run ? ST_FETCH : ST_IDLE;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          next_state = ST_MEM;
        end else begin
          next_state = ST_WB;
        end
      end
      ST_MEM: begin
        if (opcode == OP_SW) begin
          instr_done = 1'b1;
          next_state = run ? ST_FETCH : ST_IDLE;
        end else begin
          next_state = ST_WB;
        end
      end
      ST_WB: begin
        instr_done = 1'b1;
        next_state = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT:   next_state = ST_HALT;
      default:   next_state = ST_IDLE;
    endcase
  end

  assign busy   = (state != ST_IDLE) && (state != ST_HALT);
  assign halted = (state == ST_HALT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      pc      <= '0;
      pru     <= '0;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 0; i < REGS; i++) rf[i] <= '0;
    end else begin
      state <= next_state;
      case (state)
        ST_FETCH: begin
          ir <= MR[pc[IW+1:2]];
          pc <= alu_y & PC_MASK;
        end
        ST_DECODE: begin
          a_reg   <= rf[rs];
          b_reg   <= rf[rt];
          alu_out <= alu_y;
        end
        ST_EXEC: begin
          if (opcode == OP_BEQ) begin
            if (alu_zero) pc <= alu_out & PC_MASK;
          end else begin
            alu_out <= alu_y;
          end
        end
        ST_MEM:  if (opcode == OP_LW) mdr <= mem[alu_out[DW+1:2]];
        ST_WB: begin
          pru <= wb_val;
          if (wb_dst != '0) rf[wb_dst] <= wb_val;
        end
        default: ;
      endcase
    end
  end

  // NOTE: data memory has no reset; contents survive rst, which only blocks the store.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_MEM && opcode == OP_SW) mem[alu_out[DW+1:2]] <= b_reg;
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed self-checking bench for multicycle_datapath.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [31:0] pc, pru;
  logic        instr_done, busy, halted;

  int checks = 0;
  int fails  = 0;

  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

  multicycle_datapath dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .pc         (pc),
    .pru        (pru),
    .instr_done (instr_done),
    .busy       (busy),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Hold reset, fill instruction memory with halt words, release on a negedge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    for (int i = 0; i < 64; i++) dut.MR[i] = HALT_WORD;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Count negedges until instr_done is seen; an expired budget is a failure.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_done && n < 40);
    if (!instr_done) begin
      checks++;
      fails++;
      $display("FAIL wait_done timeout after %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 32'd0 || pru !== 32'd0 || instr_done !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin
      fails++;
      $display("FAIL reset_state pc=%h pru=%h done=%b busy=%b halted=%b required 0,0,0,0,0",
               pc, pru, instr_done, busy, halted);
    end
  endtask

  task automatic run_sequence(input string name, input logic [31:0] exp_pru [5]);
    int n;
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_done(n);
      checks++;
      if (n !== 4) begin
        fails++;
        $display("FAIL %s spacing[%0d] got %0d cycles required 4", name, i, n);
      end
      @(posedge clk);
      #1;
      checks++;
      if (pru !== exp_pru[i]) begin
        fails++;
        $display("FAIL %s pru[%0d] got %h required %h", name, i, pru, exp_pru[i]);
      end
    end
    run = 1'b0;
  endtask

  task automatic test_alu_chain();
    logic [31:0] exp_pru [5];
    do_reset();
    dut.MR[0] = i_type(6'h08, 0, 1, 6);
    dut.MR[1] = i_type(6'h08, 0, 2, 7);
    dut.MR[2] = r_type(1, 2, 3, 6'h20);
    dut.MR[3] = r_type(1, 2, 4, 6'h22);
    dut.MR[4] = r_type(4, 1, 5, 6'h2A);
    exp_pru = '{32'd6, 32'd7, 32'd13, 32'hFFFF_FFFF, 32'd1};
    run_sequence("alu_chain", exp_pru);
  endtask

  task automatic test_logic_ops();
    logic [31:0] exp_pru [5];
    do_reset();
    dut.MR[0] = i_type(6'h08, 0, 1, 12);
    dut.MR[1] = i_type(6'h08, 0, 2, 10);
    dut.MR[2] = r_type(1, 2, 3, 6'h24);
    dut.MR[3] = r_type(1, 2, 4, 6'h25);
    dut.MR[4] = i_type(6'h08, 0, 5, 16'hFFFF);
    exp_pru = '{32'd12, 32'd10, 32'd8, 32'd14, 32'hFFFF_FFFF};
    run_sequence("logic_ops", exp_pru);
  endtask

  task automatic test_memory();
    int n;
    do_reset();
    dut.mem[16] = 32'h0000_002A;
    dut.mem[17] = 32'h0;
    dut.MR[0] = i_type(6'h23, 0, 1, 64);
    dut.MR[1] = i_type(6'h2B, 0, 1, 68);
    run = 1'b1;
    wait_done(n);
    checks++;
    if (n !== 5) begin
      fails++;
      $display("FAIL lw_latency got %0d cycles required 5", n);
    end
    @(posedge clk);
    #1;
    checks++;
    if (pru !== 32'd42) begin
      fails++;
      $display("FAIL lw_pru got %h required %h", pru, 32'd42);
    end
    wait_done(n);
    checks++;
    if (n !== 4) begin
      fails++;
      $display("FAIL sw_latency got %0d cycles required 4", n);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut.mem[17] !== 32'd42) begin
      fails++;
      $display("FAIL sw_store mem[17] got %h required %h", dut.mem[17], 32'd42);
    end
    run = 1'b0;
  endtask

  task automatic test_branch();
    int n;
    do_reset();
    dut.MR[0] = i_type(6'h04, 0, 0, 2);
    dut.MR[1] = i_type(6'h08, 0, 1, 1);
    dut.MR[2] = i_type(6'h08, 0, 2, 2);
    dut.MR[3] = i_type(6'h08, 0, 3, 99);
    run = 1'b1;
    wait_done(n);
    checks++;
    if (n !== 3) begin
      fails++;
      $display("FAIL beq_latency got %0d cycles required 3", n);
    end
    @(posedge clk);
    #1;
    checks++;
    if (pc !== 32'd12) begin
      fails++;
      $display("FAIL beq_target pc got %h required %h", pc, 32'd12);
    end
    wait_done(n);
    @(posedge clk);
    #1;
    checks++;
    if (pru !== 32'd99) begin
      fails++;
      $display("FAIL beq_next_fetch pru got %h required %h", pru, 32'd99);
    end
    run = 1'b0;
  endtask

  task automatic test_halt();
    int n;
    int bad;
    do_reset();
    dut.MR[0] = i_type(6'h08, 0, 1, 3);
    dut.MR[1] = i_type(6'h08, 0, 2, 4);
    dut.MR[2] = HALT_WORD;
    run = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!halted && n < 60);
    checks++;
    if (n !== 11) begin
      fails++;
      $display("FAIL halt_latency got %0d cycles required 11", n);
    end
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || pc !== 32'd12) begin
      fails++;
      $display("FAIL halt_state halted=%b busy=%b pc=%h required 1,0,0000000c", halted, busy, pc);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pc !== 32'd12 || instr_done !== 1'b0 || halted !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL halt_hold %0d bad cycles required 0", bad);
    end
    checks++;
    if (pru !== 32'd4 || dut.rf[1] !== 32'd3 || dut.rf[2] !== 32'd4 || dut.rf[3] !== 32'd0) begin
      fails++;
      $display("FAIL halt_regs pru=%h r1=%h r2=%h r3=%h required 4,3,4,0",
               pru, dut.rf[1], dut.rf[2], dut.rf[3]);
    end
    run = 1'b0;
  endtask

  task automatic test_run_drop();
    int n;
    do_reset();
    dut.MR[0] = i_type(6'h08, 0, 1, 5);
    dut.MR[1] = r_type(1, 1, 2, 6'h20);
    dut.MR[2] = i_type(6'h08, 0, 3, 1);
    run = 1'b1;
    wait_done(n);
    repeat (3) @(negedge clk);
    run = 1'b0;
    wait_done(n);
    checks++;
    if (n !== 1) begin
      fails++;
      $display("FAIL run_drop_complete got %0d cycles required 1", n);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (pru !== 32'd10 || busy !== 1'b0 || halted !== 1'b0 || pc !== 32'd8) begin
      fails++;
      $display("FAIL run_drop_idle pru=%h busy=%b halted=%b pc=%h required 0000000a,0,0,00000008",
               pru, busy, halted, pc);
    end
  endtask

  task automatic test_reset_in_wb();
    int n;
    do_reset();
    dut.MR[0] = i_type(6'h08, 0, 1, 9);
    dut.MR[1] = i_type(6'h08, 0, 2, 7);
    run = 1'b1;
    wait_done(n);
    repeat (4) @(negedge clk);
    checks++;
    if (instr_done !== 1'b1) begin
      fails++;
      $display("FAIL rst_wb_setup done got %b required 1", instr_done);
    end
    rst = 1'b1;
    run = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (pru !== 32'd0 || pc !== 32'd0 || busy !== 1'b0 || halted !== 1'b0 || dut.rf[2] !== 32'd0) begin
      fails++;
      $display("FAIL rst_wb pru=%h pc=%h busy=%b halted=%b r2=%h required all 0",
               pru, pc, busy, halted, dut.rf[2]);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reg0();
    int n;
    do_reset();
    dut.MR[0] = i_type(6'h08, 0, 0, 5);
    dut.MR[1] = r_type(0, 0, 1, 6'h20);
    run = 1'b1;
    wait_done(n);
    @(posedge clk);
    #1;
    checks++;
    if (pru !== 32'd5) begin
      fails++;
      $display("FAIL reg0_pru_write got %h required %h", pru, 32'd5);
    end
    wait_done(n);
    @(posedge clk);
    #1;
    checks++;
    if (pru !== 32'd0 || dut.rf[0] !== 32'd0) begin
      fails++;
      $display("FAIL reg0_reads_zero pru=%h r0=%h required 0,0", pru, dut.rf[0]);
    end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_logic_ops();
    test_memory();
    test_branch();
    test_halt();
    test_run_drop();
    test_reset_in_wb();
    test_reg0();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multicycle successor to the single-cycle datapath: one instruction executes over 3–5 clocks, sequenced by an internal FSM, with a single shared ALU. The block holds its own instruction memory, data memory and register file. It runs a reduced MIPS-style ISA under a `run`/`halted` control handshake and sits at the top of the processor hierarchy as the unit the bench drives directly.

## Interface
- `WIDTH`, 32: data, register and PC width.
- `REGS`, 32: register count, power of two; register 0 reads zero.
- `IMEM_DEPTH`, 64: instruction words, power of two.
- `DMEM_DEPTH`, 64: data words, power of two.
- `clk  in  1`: clock. One clock; reset is synchronous and active-high.
- `rst  in  1`: synchronous active-high reset.
- `run  in  1`: level; permits fetching new instructions.
- `pc  out  WIDTH`: byte address of the current instruction.
- `pru  out  WIDTH`: value of the most recent register-file write.
- `instr_done  out  1`: one-cycle pulse in the final state of each instruction.
- `busy  out  1`: high in any state except IDLE and HALT.
- `halted  out  1`: high in HALT.

## Operation
- Reset values:
  - `pc` = 0, `pru` = 0.
  - `instr_done`, `busy` and `halted` = 0.
  - State = IDLE.
  - Register file cleared.
  - Memory contents are not reset; the bench preloads instruction array `MR` and data array `mem`.
- FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE:
  - Goes to FETCH if `run`=1, else stays in IDLE.
  - After any `instr_done`, the FSM returns to FETCH if `run`=1, else to IDLE.
  - Deasserting `run` mid-instruction never aborts the instruction.
- FETCH: IR <= `MR[pc[log2(IMEM_DEPTH)+1:2]]`; pc <= pc+4, wrapping modulo IMEM_DEPTH*4.
- DECODE:
  - A <= rs, B <= rt.
  - imm = sign-extended IR[15:0].
  - Unknown opcode or funct goes to HALT; nothing is written.
- Supported instructions:
  - R-type, opcode 0x00: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed). Writes rd.
  - addi 0x08: writes rt.
  - lw 0x23, sw 0x2B: address = A+imm; data index = addr[log2(DMEM_DEPTH)+1:2], wrapping.
  - beq 0x04: if A==B, pc <= (pc)+(imm<<2), using the already-incremented pc.
- Arithmetic is modulo 2^WIDTH; overflow is ignored and never traps.
- Writes to register 0 are discarded, but `pru` still updates with the value.
- HALT is left only by `rst`.

## Timing
- Data memory and register-file reads are combinational; all writes land on the clock edge.
- Path lengths in cycles, counting from FETCH entry; `instr_done` is asserted in the last state listed:
  - R-type: F, D, E, WB = 4.
  - addi: 4.
  - lw: F, D, E, MEM, WB = 5.
  - sw: F, D, E, MEM = 4; the store lands at the MEM clock edge.
  - beq: F, D, E = 3; pc is updated at the E edge.
- `pru` and the register write update on the same edge.
- The first FETCH begins the cycle after `run` is sampled high in IDLE.
- `rst` overrides every write in the same cycle, with no partial commit. Data memory keeps its contents across reset.
- Unknown opcode: `halted` rises the cycle after DECODE; `instr_done` does not pulse.

## Structure
- Shared package `datapath_pkg` holds:
  - opcode and funct constants;
  - FSM state encoding;
  - the 3-bit ALU op encoding (ADD, SUB, AND, OR, SLT).
- Sub-module `datapath_alu`: combinational, parameterised by WIDTH; inputs a, b, op; outputs y and zero.
- All remaining logic lives at top level: FSM, IR/A/B/ALUOut registers, register file, memories.

## Test plan
- ALU chain:
  - Stimulus: `addi $1,$0,6`; `addi $2,$0,7`; `add $3,$1,$2`; `sub $4,$1,$2`; `slt $5,$4,$1`.
  - Expected: `pru` sequence 6, 7, 13, 0xFFFFFFFF, 1; each `instr_done` 4 cycles apart.
- Memory:
  - Stimulus: data word 16 preloaded with 0x0000002A; `lw $1,64($0)`; `sw $1,68($0)`.
  - Expected: `pru`=42 after 5 cycles; `mem[17]`=42 after 4 further cycles.
- Branch:
  - Stimulus: `beq $0,$0,2` at pc 0.
  - Expected: `pc`=12 after 3 cycles; the next fetch comes from word 3.
- Halt:
  - Stimulus: opcode 0x3F at pc 8.
  - Expected: `halted`=1 and `busy`=0; `pc` holds 12 for 20 cycles; no register changes.
- Run and reset:
  - Stimulus: `run` dropped during the EXEC of an add.
  - Expected: the add completes, then the FSM sits in IDLE with `pc` held.
  - Stimulus: `rst` pulsed in the WB cycle.
  - Expected: no register write, `pru`=0, `pc`=0, state IDLE.
- Register 0:
  - Stimulus: `addi $0,$0,5` followed by `add $1,$0,$0`.
  - Expected: `pru`=5 then `pru`=0.
